mem_uart_dump: RTL and testbench
================================

Name: mem_uart_dump

Overview:
Readback engine for the 16-word data memory: the opposite direction of the UART-to-memory loader.
- On a start pulse it reads words 0..DEPTH-1 through the memory read port.
- It splits each word into two bytes, MSB first, and hands them to the UART transmitter over a valid/ready byte handshake.
- It optionally appends a CRC-8 trailer byte so the host can check the dump.
- It sits between the data memory read port and the UART TX byte interface, alongside the existing loader.

Parameters:
DEPTH, 16, number of words dumped (addresses 0..DEPTH-1); legal range 1..16.
ADDR_W, 4, memory address width.
CRC_EN, 1, 1 = append a CRC-8 byte after the data; 0 = no trailer.
CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a dump; ignored unless in IDLE.
abort  input  1  synchronous cancel of a dump in progress.
mem_addr  output  ADDR_W  memory read address.
mem_rd_en  output  1  high while mem_addr is being sampled.
mem_rd_data  input  16  memory read data; combinational read, valid in the same cycle as mem_addr.
tx_data  output  8  byte to the UART transmitter.
tx_valid  output  1  tx_data is valid.
tx_ready  input  1  transmitter accepts the byte.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the final byte is accepted.
crc_out  output  8  CRC of the last completed dump.

Behaviour:
- Reset (async, active-low), all registered outputs and state:
  - state = IDLE; mem_addr = 0; mem_rd_en = 0.
  - tx_data = 0; tx_valid = 0; busy = 0; done = 0.
  - crc_out = 0; word register = 0; CRC accumulator = 0.
- Reset mid-dump: tx_valid drops immediately. No done pulse. The partial dump is lost.
- States: IDLE, FETCH, SEND_HI, SEND_LO, SEND_CRC, FINISH.
- IDLE:
  - start=1 clears the word index and the CRC accumulator, then goes to FETCH.
  - start in any other state is ignored and not queued.
- FETCH:
  - mem_addr = index; mem_rd_en = 1.
  - Registers mem_rd_data into the word register, then goes to SEND_HI.
- Latency: start is sampled at edge N; FETCH runs in cycle N+1; tx_valid is first high in cycle N+2.
- SEND_HI:
  - tx_valid = 1; tx_data = word[15:8].
  - On tx_valid && tx_ready at a rising edge: update the CRC with the byte, then go to SEND_LO.
- SEND_LO:
  - Same handshake with tx_data = word[7:0].
  - On acceptance, if index == DEPTH-1: go to SEND_CRC if CRC_EN=1, else FINISH.
  - Otherwise increment index and go to FETCH.
- SEND_CRC: sends the CRC accumulator as tx_data. On acceptance, goes to FINISH.
- FINISH:
  - done = 1 for exactly one cycle; crc_out is loaded with the final CRC.
  - Next state is IDLE.
  - crc_out holds until the next FINISH.
- Handshake rules:
  - Once tx_valid rises, tx_valid and tx_data stay stable until accepted.
  - tx_valid deasserts only on acceptance, abort, or reset.
  - tx_ready may be held high permanently; a byte is then accepted every cycle it is valid.
  - With tx_ready always high, a word takes 3 cycles (FETCH, HI, LO).
- Total bytes per dump: 2*DEPTH + CRC_EN.
- Index arithmetic:
  - index is ADDR_W bits.
  - The terminal test is an equality compare against DEPTH-1, so there is no wrap for DEPTH=16.
  - index never exceeds DEPTH-1.
- CRC-8:
  - Polynomial CRC_POLY, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over the data bytes in transmitted order.
  - The CRC byte is not included in its own computation.
- abort:
  - Sampled high in any non-IDLE state: the next state is IDLE, tx_valid = 0 at the next edge, no done, crc_out unchanged.
  - A handshake completing on the same edge as abort is still a valid transfer from the transmitter's side, but the block goes to IDLE.
  - abort in IDLE has no effect.
  - start and abort together in IDLE: start wins.
- Memory contents are never written by this block. Memory changing mid-dump is not protected; each word is sampled once in its FETCH cycle.

Test Plan:
- Reset, then start with tx_ready=1, DEPTH=16, CRC_EN=1, memory at reset values (mem[i]=i).
  - Required: 33 bytes 00,00,00,01,...,00,0F, then the CRC byte matching the CRC-8/0x07 model.
  - Required: done pulses once; crc_out equals the CRC byte; busy falls with done.
- DEPTH=1, mem[0]=16'h0001, CRC_EN=1.
  - Required: bytes 00, 01, 07; crc_out = 8'h07; tx_valid first high 2 cycles after start.
- Backpressure: tx_ready low for 5 cycles on each byte.
  - Required: tx_data and tx_valid held stable through every stall; byte order unchanged; no duplicates or drops.
- abort asserted during SEND_LO of word 3.
  - Required: tx_valid low next cycle, state IDLE, no done, crc_out keeps its previous value.
  - A new start then dumps from word 0.
- start pulsed while busy: ignored, dump unaffected.
  - Async reset mid-SEND_HI: all outputs go to reset values with no clock edge.
- CRC_EN=0, DEPTH=16: exactly 32 bytes, done one cycle after the last acceptance, no trailer byte.

Source files
------------

// File: rtl/mem_uart_dump.sv
// Memory readback engine: streams words 0..DEPTH-1 MSB-first as bytes over a valid/ready
// interface, optionally followed by a CRC-8 trailer over the data bytes.
module mem_uart_dump #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          CRC_EN   = 1'b1,
  parameter logic [7:0]  CRC_POLY = 8'h07
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [15:0]       mem_rd_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        crc_out_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSendHi,
    StSendLo,
    StSendCrc,
    StFinish
  } state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       word_q, word_d;
  logic [7:0]        crc_q, crc_d;
  logic [7:0]        crc_out_q, crc_out_d;

  // MSB-first CRC-8, init 0, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ (c[7] ? CRC_POLY : 8'h00);
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    crc_d       = crc_q;
    crc_out_d   = crc_out_q;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    mem_rd_en_o = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          crc_d   = 8'h00;
          state_d = StFetch;
        end
      end
      StFetch: begin
        mem_rd_en_o = 1'b1;
        word_d      = mem_rd_data_i;
        state_d     = StSendHi;
      end
      StSendHi: begin
        tx_valid_o = 1'b1;
        tx_data_o  = word_q[15:8];
        if (tx_ready_i) begin
          crc_d   = crc8_byte(crc_q, word_q[15:8]);
          state_d = StSendLo;
        end
      end
      StSendLo: begin
        tx_valid_o = 1'b1;
        tx_data_o  = word_q[7:0];
        if (tx_ready_i) begin
          crc_d = crc8_byte(crc_q, word_q[7:0]);
          if (idx_q == LastIdx) begin
            if (CRC_EN) begin
              state_d = StSendCrc;
            end else begin
              // No trailer: latch the final CRC as we enter StFinish so it is valid with done.
              crc_out_d = crc_d;
              state_d   = StFinish;
            end
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
      end
      StSendCrc: begin
        tx_valid_o = 1'b1;
        tx_data_o  = crc_q;
        if (tx_ready_i) begin
          crc_out_d = crc_q;
          state_d   = StFinish;
        end
      end
      StFinish: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides any transition, including a completing handshake.
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      crc_out_d = crc_out_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      word_q    <= 16'h0000;
      crc_q     <= 8'h00;
      crc_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign mem_addr_o = idx_q;
  assign busy_o     = (state_q != StIdle);
  assign crc_out_o  = crc_out_q;

endmodule

// File: tb/tb_mem_uart_dump.sv
// Directed bench for mem_uart_dump: three instances cover the default configuration,
// a single-word dump and a dump without the CRC trailer.
module tb_mem_uart_dump;

  typedef logic [7:0] byte_q_t[$];

  logic clk;
  logic reset;

  // Instance A: DEPTH=16, CRC_EN=1
  logic        a_start, a_abort, a_rd_en, a_tx_valid, a_tx_ready, a_busy, a_done;
  logic [3:0]  a_addr;
  logic [15:0] a_rd_data;
  logic [7:0]  a_tx_data, a_crc_out;
  // Instance B: DEPTH=1, CRC_EN=1
  logic        b_start, b_abort, b_rd_en, b_tx_valid, b_tx_ready, b_busy, b_done;
  logic [3:0]  b_addr;
  logic [15:0] b_rd_data;
  logic [7:0]  b_tx_data, b_crc_out;
  // Instance C: DEPTH=16, CRC_EN=0
  logic        c_start, c_abort, c_rd_en, c_tx_valid, c_tx_ready, c_busy, c_done;
  logic [3:0]  c_addr;
  logic [15:0] c_rd_data;
  logic [7:0]  c_tx_data, c_crc_out;

  logic [15:0] mem_a[16];
  logic [15:0] mem_b[16];
  logic [15:0] mem_c[16];

  assign a_rd_data = mem_a[a_addr];
  assign b_rd_data = mem_b[b_addr];
  assign c_rd_data = mem_c[c_addr];

  mem_uart_dump u_a (
    .clk(clk), .reset(reset), .start_i(a_start), .abort_i(a_abort),
    .mem_addr_o(a_addr), .mem_rd_en_o(a_rd_en), .mem_rd_data_i(a_rd_data),
    .tx_data_o(a_tx_data), .tx_valid_o(a_tx_valid), .tx_ready_i(a_tx_ready),
    .busy_o(a_busy), .done_o(a_done), .crc_out_o(a_crc_out)
  );

  mem_uart_dump #(.DEPTH(1)) u_b (
    .clk(clk), .reset(reset), .start_i(b_start), .abort_i(b_abort),
    .mem_addr_o(b_addr), .mem_rd_en_o(b_rd_en), .mem_rd_data_i(b_rd_data),
    .tx_data_o(b_tx_data), .tx_valid_o(b_tx_valid), .tx_ready_i(b_tx_ready),
    .busy_o(b_busy), .done_o(b_done), .crc_out_o(b_crc_out)
  );

  mem_uart_dump #(.CRC_EN(1'b0)) u_c (
    .clk(clk), .reset(reset), .start_i(c_start), .abort_i(c_abort),
    .mem_addr_o(c_addr), .mem_rd_en_o(c_rd_en), .mem_rd_data_i(c_rd_data),
    .tx_data_o(c_tx_data), .tx_valid_o(c_tx_valid), .tx_ready_i(c_tx_ready),
    .busy_o(c_busy), .done_o(c_done), .crc_out_o(c_crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  byte_q_t got_a, got_b, got_c;
  int a_done_cnt = 0, b_done_cnt = 0, c_done_cnt = 0;

  // Inputs change at posedge+1, so the negedge sees exactly what the next edge will accept.
  always @(negedge clk) begin
    if (a_tx_valid && a_tx_ready) got_a.push_back(a_tx_data);
    if (b_tx_valid && b_tx_ready) got_b.push_back(b_tx_data);
    if (c_tx_valid && c_tx_ready) got_c.push_back(c_tx_data);
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (c_done) c_done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag, input byte_q_t got, input byte_q_t exp);
    chk({tag, " byte count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s byte %0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    end
  endtask

  // Serial-form CRC-8: one message bit per step into the x^8+x^2+x+1 divider.
  function automatic logic [7:0] crc_model(input byte_q_t bytes);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    foreach (bytes[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb  = crc[7] ^ bytes[i][b];
        crc = {crc[6:0], 1'b0};
        if (fb) crc = crc ^ 8'h07;
      end
    end
    return crc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (!a_done && n < 400) begin
      tick();
      n++;
    end
    chk({tag, " done within budget"}, a_done, 1'b1);
  endtask

  byte_q_t    exp_a, exp_c, exp_b;
  logic [7:0] crc_a, crc_c;
  int         cnt0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'(i);
      mem_b[i] = 16'h0000;
      mem_c[i] = {8'(8'hC0 + i), 8'(8'h3F - i)};
    end
    mem_b[0] = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      exp_a.push_back(mem_a[i][15:8]);
      exp_a.push_back(mem_a[i][7:0]);
      exp_c.push_back(mem_c[i][15:8]);
      exp_c.push_back(mem_c[i][7:0]);
    end
    crc_a = crc_model(exp_a);
    crc_c = crc_model(exp_c);
    exp_a.push_back(crc_a);
    exp_b = '{8'h00, 8'h01, 8'h07};

    {a_start, a_abort, a_tx_ready} = '0;
    {b_start, b_abort, b_tx_ready} = '0;
    {c_start, c_abort, c_tx_ready} = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset busy", a_busy, 1'b0);
    chk("reset tx_valid", a_tx_valid, 1'b0);
    chk("reset tx_data", a_tx_data, 8'h00);
    chk("reset done", a_done, 1'b0);
    chk("reset crc_out", a_crc_out, 8'h00);
    chk("reset mem_rd_en", a_rd_en, 1'b0);
    chk("reset mem_addr", a_addr, 4'h0);
    tick();
    reset = 1'b1;
    tick();

    // Full dump, tx_ready held high
    a_tx_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("full fetch rd_en", a_rd_en, 1'b1);
    chk("full fetch addr", a_addr, 4'h0);
    chk("full fetch tx_valid", a_tx_valid, 1'b0);
    chk("full fetch busy", a_busy, 1'b1);
    tick();
    chk("full first valid", {a_tx_valid, a_tx_data}, {1'b1, 8'h00});
    wait_done_a("full");
    chk("full busy with done", a_busy, 1'b1);
    chk("full crc_out", a_crc_out, crc_a);
    tick();
    chk("full done one cycle", a_done, 1'b0);
    chk("full busy falls", a_busy, 1'b0);
    chk("full done count", a_done_cnt, 1);
    chk_stream("full", got_a, exp_a);

    // Backpressure: 5 stall cycles before every byte
    got_a.delete();
    cnt0 = a_done_cnt;
    a_tx_ready = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < exp_a.size(); i++) begin
      int n;
      n = 0;
      while (!a_tx_valid && n < 4) begin
        tick();
        n++;
      end
      chk($sformatf("bp valid rises byte %0d", i), a_tx_valid, 1'b1);
      for (int s = 0; s < 5; s++) begin
        chk($sformatf("bp stall byte %0d cyc %0d", i, s), {a_tx_valid, a_tx_data},
            {1'b1, exp_a[i]});
        tick();
      end
      a_tx_ready = 1'b1;
      chk($sformatf("bp accept byte %0d", i), {a_tx_valid, a_tx_data}, {1'b1, exp_a[i]});
      tick();
      a_tx_ready = 1'b0;
    end
    chk("bp done", a_done, 1'b1);
    chk("bp crc_out", a_crc_out, crc_a);
    tick();
    chk("bp done count", a_done_cnt, cnt0 + 1);
    chk_stream("bp", got_a, exp_a);

    // Abort during SEND_LO of word 3 (cycle N+12 after start edge N)
    got_a.delete();
    cnt0 = a_done_cnt;
    a_tx_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (11) tick();
    chk("abort at word3 lo", {a_tx_valid, a_tx_data}, {1'b1, 8'h03});
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort tx_valid", a_tx_valid, 1'b0);
    chk("abort busy", a_busy, 1'b0);
    chk("abort done", a_done, 1'b0);
    chk("abort crc_out kept", a_crc_out, crc_a);
    tick();
    tick();
    chk("abort no done pulse", a_done_cnt, cnt0);
    chk("abort bytes sent", got_a.size(), 8);

    // Restart from word 0 with a stray start while busy
    got_a.delete();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (3) tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done_a("restart");
    chk("restart crc_out", a_crc_out, crc_a);
    tick();
    chk("restart done count", a_done_cnt, cnt0 + 1);
    chk_stream("restart", got_a, exp_a);

    // Asynchronous reset mid SEND_HI
    cnt0 = a_done_cnt;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    chk("arst pre hi", {a_tx_valid, a_tx_data}, {1'b1, 8'h00});
    #2 reset = 1'b0;
    #1;
    chk("arst tx_valid", a_tx_valid, 1'b0);
    chk("arst tx_data", a_tx_data, 8'h00);
    chk("arst busy", a_busy, 1'b0);
    chk("arst crc_out", a_crc_out, 8'h00);
    chk("arst mem_rd_en", a_rd_en, 1'b0);
    chk("arst mem_addr", a_addr, 4'h0);
    reset = 1'b1;
    tick();
    chk("arst stays idle", a_busy, 1'b0);
    chk("arst no done", a_done_cnt, cnt0);
    a_tx_ready = 1'b0;

    // DEPTH=1
    b_tx_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("d1 fetch tx_valid", b_tx_valid, 1'b0);
    tick();
    chk("d1 first valid", {b_tx_valid, b_tx_data}, {1'b1, 8'h00});
    repeat (3) tick();
    chk("d1 done", b_done, 1'b1);
    chk("d1 crc_out", b_crc_out, 8'h07);
    tick();
    chk("d1 idle", b_busy, 1'b0);
    chk("d1 done count", b_done_cnt, 1);
    chk_stream("d1", got_b, exp_b);

    // CRC_EN=0: last LO accepted at N+48, done at N+49
    c_tx_ready = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    repeat (47) tick();
    chk("nocrc last byte", {c_tx_valid, c_tx_data}, {1'b1, 8'h30});
    tick();
    chk("nocrc done", {c_done, c_tx_valid}, {1'b1, 1'b0});
    chk("nocrc crc_out", c_crc_out, crc_c);
    tick();
    chk("nocrc idle", c_busy, 1'b0);
    chk("nocrc done count", c_done_cnt, 1);
    chk_stream("nocrc", got_c, exp_c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
